// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: ALU codes, opcodes, funct
// values, mux select encodings and the control FSM state type.
package mips_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // S_BRANCH_NE only becomes reachable when bne support is compiled in.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_ALU_WB    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_BRANCH    = 4'd8,
    S_BRANCH_NE = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_HALT      = 4'd13
  } state_e;

endpackage

// File: rtl/mips_mc_control_funct_decode.sv
// R-type funct -> ALU operation decoder; shared with single-cycle control.
// Unknown funct values report valid_o=0 and a harmless AND code.
module mips_funct_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [1:0] alu_control_o,
  output logic       valid_o
);

  always_comb begin
    alu_control_o = ALU_AND;
    valid_o       = 1'b1;
    case (funct_i)
      FN_AND:  alu_control_o = ALU_AND;
      FN_XOR:  alu_control_o = ALU_XOR;
      FN_ADD:  alu_control_o = ALU_ADD;
      FN_SUB:  alu_control_o = ALU_SUB;
      default: valid_o       = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM. Optional bne support via MIPS_MC_BNE_EN.
// ILLEGAL_HALT selects HALT (1) or NOP retirement (0) for illegal encodings.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       z_flag,
  input  logic       mem_ready,
  output logic [1:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       halted
);

  localparam state_e ILLEGAL_NEXT = ILLEGAL_HALT ? S_HALT : S_FETCH;

  state_e state_q, state_d;

  logic [1:0] r_alu;
  logic       r_valid;

  logic [1:0] alu_control_c, alu_src_b_c, pc_source_c;
  logic       alu_src_a_c, pc_en_c, iord_c, mem_read_c, mem_write_c;
  logic       ir_write_c, reg_dst_c, mem_to_reg_c, reg_write_c, halted_c;

  mips_funct_decode u_fdec (
    .funct_i       (funct),
    .alu_control_o (r_alu),
    .valid_o       (r_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    alu_control_c = ALU_AND;
    alu_src_a_c   = 1'b0;
    alu_src_b_c   = SRCB_REG;
    pc_source_c   = PCSRC_ALU;
    pc_en_c       = 1'b0;
    iord_c        = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    reg_dst_c     = 1'b0;
    mem_to_reg_c  = 1'b0;
    reg_write_c   = 1'b0;
    halted_c      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c    = 1'b1;
        alu_src_b_c   = SRCB_FOUR;
        alu_control_c = ALU_ADD;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only compares.
        alu_src_b_c   = SRCB_IMM_SH2;
        alu_control_c = ALU_ADD;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = S_BRANCH_NE;
`endif
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = ILLEGAL_NEXT;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_c   = 1'b1;
        alu_control_c = r_alu;
        state_d       = r_valid ? S_ALU_WB : ILLEGAL_NEXT;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = SRCB_IMM;
        alu_control_c = ALU_ADD;
        state_d       = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c   = 1'b1;
        alu_control_c = ALU_SUB;
        pc_source_c   = PCSRC_ALUOUT;
        pc_en_c       = z_flag;
        state_d       = S_FETCH;
      end
`ifdef MIPS_MC_BNE_EN
      S_BRANCH_NE: begin
        alu_src_a_c   = 1'b1;
        alu_control_c = ALU_SUB;
        pc_source_c   = PCSRC_ALUOUT;
        pc_en_c       = ~z_flag;
        state_d       = S_FETCH;
      end
`endif
      S_JUMP: begin
        pc_source_c = PCSRC_JUMP;
        pc_en_c     = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a_c   = 1'b1;
        alu_src_b_c   = SRCB_IMM;
        alu_control_c = ALU_ADD;
        state_d       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: halted_c = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every output combinationally so an in-flight write dies at once.
  assign alu_control = rst_n ? alu_control_c : 2'b00;
  assign alu_src_a   = rst_n & alu_src_a_c;
  assign alu_src_b   = rst_n ? alu_src_b_c : 2'b00;
  assign pc_source   = rst_n ? pc_source_c : 2'b00;
  assign pc_en       = rst_n & pc_en_c;
  assign iord        = rst_n & iord_c;
  assign mem_read    = rst_n & mem_read_c;
  assign mem_write   = rst_n & mem_write_c;
  assign ir_write    = rst_n & ir_write_c;
  assign reg_dst     = rst_n & reg_dst_c;
  assign mem_to_reg  = rst_n & mem_to_reg_c;
  assign reg_write   = rst_n & reg_write_c;
  assign halted      = rst_n & halted_c;

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Multicycle MIPS main control FSM, sitting opposite the ALU on the datapath.
- Drives the 2-bit ALU operation code and the z_flag is consumed back from the ALU.
- Sequences fetch/decode/execute/memory/writeback per instruction.
- Drives every datapath mux select and write enable.
- Waits on a memory-ready handshake.

Parameters:
ILLEGAL_HALT, 1, 1: an illegal opcode enters HALT until reset; 0: an illegal opcode is retired as a NOP (back to FETCH).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
funct  input  6  IR[5:0]
z_flag  input  1  ALU equality flag, sampled combinationally in BRANCH
mem_ready  input  1  memory completes the current access this cycle
alu_control  output  2  00 AND, 01 XOR, 10 ADD, 11 SUB
alu_src_a  output  1  0 PC, 1 register A
alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
pc_en  output  1  PC load enable (already qualified by branch/z_flag)
iord  output  1  0 PC addresses memory, 1 ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  latch instruction register
reg_dst  output  1  0 rt, 1 rd
mem_to_reg  output  1  0 ALUOut, 1 MDR
reg_write  output  1  register file write enable
halted  output  1  FSM in HALT

Behaviour:
- Reset: state=FETCH. All enables (pc_en, mem_read, mem_write, ir_write, reg_write) are 0 while rst_n=0.
  - All selects are 0 while rst_n=0.
  - halted=0.
- Outputs are Moore decoded from state; the only exceptions are pc_en, ir_write and mem-stage advance, which also depend on mem_ready/z_flag.
- Default outputs in every state: all enables 0, selects 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=10, pc_source=00.
  - When mem_ready=1: ir_write=1 and pc_en=1, go to DECODE.
  - Otherwise stay in FETCH with no PC/IR write.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=10 (branch target precompute).
  - Next state by opcode: 0x00 -> EXEC_R; 0x23/0x2B -> MEM_ADDR; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDI_EXEC.
  - Any other opcode -> HALT if ILLEGAL_HALT=1, else FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_control from funct: 0x24->00, 0x26->01, 0x20->10, 0x22->11.
  - Unknown funct -> HALT (or FETCH when ILLEGAL_HALT=0), with reg_write suppressed.
  - Valid funct -> ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_control=10. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1; hold until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WRITE: mem_write=1, iord=1; hold until mem_ready, then -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=11, pc_source=01, pc_en=z_flag -> FETCH.
- JUMP: pc_source=10, pc_en=1 -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_control=10 -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- HALT: all enables 0, halted=1; leaves only on reset.
- Latency in cycles, zero-wait memory:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each mem_ready=0 cycle adds one cycle.
- mem_read/mem_write remain asserted and stable for the whole wait; the address select must not change while waiting.
- Asynchronous reset mid-instruction (including during a memory wait) returns to FETCH immediately; no partial write completes after reset asserts.
- Unreachable state encodings decode to FETCH.

Optional Feature:
MIPS_MC_BNE_EN
- Defined: opcode 0x05 (bne) decodes to BRANCH_NE, which is identical to BRANCH except pc_en=~z_flag.
- Undefined: 0x05 is an illegal opcode handled per ILLEGAL_HALT.

Decomposition:
- Shared package mips_pkg holds:
  - ALU code constants (ALU_AND=2'b00, ALU_XOR=2'b01, ALU_ADD=2'b10, ALU_SUB=2'b11), so the ALU and this block agree.
  - Opcode and funct constants.
  - State enum typedef.
  - alu_src_b and pc_source select encodings.
- One natural sub-module, mips_funct_decode: combinational funct -> {alu_control, valid}, reused by a future single-cycle control.

Test Plan:
- add $3,$1,$2 (opcode 0x00, funct 0x20), mem_ready=1:
  - Expect FETCH, DECODE, EXEC_R, ALU_WB.
  - Expect alu_control=10 in EXEC_R; reg_write=1, reg_dst=1 in cycle 4; pc_en=1 only in cycle 1.
- lw with mem_ready low for 3 cycles in MEM_READ:
  - Expect mem_read=1, iord=1 held for 4 cycles.
  - Expect MEM_WB reg_write=1, mem_to_reg=1; 8 cycles total.
- beq (0x04) with z_flag=1, then repeat with z_flag=0:
  - Expect pc_en=1, pc_source=01 in BRANCH vs pc_en=0; alu_control=11 in both.
- Opcode 0x3F with ILLEGAL_HALT=1:
  - Expect HALT, halted=1, no enables for 10 cycles.
  - After rst_n pulse, expect FETCH.
- sw with rst_n asserted during mem_ready=0 wait:
  - Expect mem_write=0 immediately and state FETCH; no mem_write after release until the next sw reaches MEM_WRITE.
- funct sweep 0x24/0x26/0x20/0x22:
  - Expect alu_control 00/01/10/11.
  - funct 0x27 -> no reg_write, HALT.
